// File: rtl/cla_nibble_serial_adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cla_seq_pkg
// Description : Shared types and constants for the nibble-serial CLA adder
//               sequencer: state encoding, nibble width and the nibble-index
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cla_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble counter for a given operand width; never below 1.
    function automatic int calc_idx_w(input int width);
        int nibbles;
        int w;
        nibbles = width / NIBBLE_W;
        w = 0;
        while ((1 << w) < nibbles) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_nibble_serial_adder_ctrl_cla4.sv
`default_nettype none
// ============================================================================
// Module      : four_bit_CLA_adder
// Description : Combinational 4-bit carry-lookahead adder with carry-in and
//               carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
module four_bit_CLA_adder (
    output logic [3:0] sum,
    output logic       c4,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    // Generate/propagate terms and flattened lookahead carries.
    always_comb begin
        w_p = a ^ b;
        w_g = a & b;
        w_c[0] = c0;
        w_c[1] = w_g[0] | (w_p[0] & c0);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c0);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & c0);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & c0);
        sum = w_p ^ w_c[3:0];
        c4  = w_c[4];
    end

endmodule
`default_nettype wire

// File: rtl/cla_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cla_nibble_serial_adder_ctrl
// Description : Performs WIDTH-bit additions by running one 4-bit CLA over
//               WIDTH/4 cycles, LSB nibble first, carry chained through a
//               register. valid/ready handshakes on operand and result sides.
//               Optional macro CLA_SEQ_SUB_EN adds an op_sub input selecting
//               a - b (B inverted, nibble-0 carry-in forced to 1).
// Revision    : 1.0 - initial release
// ============================================================================
module cla_nibble_serial_adder_ctrl
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = calc_idx_w(WIDTH);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NIBBLES - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic [WIDTH-1:0] w_beff;
    logic [3:0]       w_nib_sum;
    logic             w_nib_c4;
    logic             w_last;
    logic             w_accept;
    logic             w_start_carry;

`ifdef CLA_SEQ_SUB_EN
    logic             r_sub;

    // Subtraction feeds the adder with ~B; the +1 comes from the start carry.
    always_comb begin
        w_beff        = r_sub ? ~r_b : r_b;
        w_start_carry = op_sub ? 1'b1 : cin;
    end

    // Operation select is captured alongside the operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sub <= 1'b0;
        end else if (w_accept) begin
            r_sub <= op_sub;
        end
    end
`else
    // Plain addition: B passes through and cin seeds nibble 0.
    always_comb begin
        w_beff        = r_b;
        w_start_carry = cin;
    end
`endif

    four_bit_CLA_adder u_cla (
        .sum (w_nib_sum),
        .c4  (w_nib_c4),
        .a   (r_a[{r_idx, 2'b00} +: NIBBLE_W]),
        .b   (w_beff[{r_idx, 2'b00} +: NIBBLE_W]),
        .c0  (r_carry)
    );

    // Handshake qualifiers and the last-nibble flag.
    always_comb begin
        w_accept = (r_state == IDLE) && in_valid;
        w_last   = (r_idx == c_last_idx);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE on last nibble,
    // DONE -> IDLE once the consumer takes the result.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, one nibble per RUN cycle, flags on the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= w_start_carry;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                RUN: begin
                    r_sum[{r_idx, 2'b00} +: NIBBLE_W] <= w_nib_sum;
                    r_carry <= w_nib_c4;
                    if (w_last) begin
                        r_idx  <= '0;
                        r_cout <= w_nib_c4;
                        r_ovf  <= (r_a[WIDTH-1] == w_beff[WIDTH-1]) &&
                                  (w_nib_sum[NIBBLE_W-1] != r_a[WIDTH-1]);
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output mapping.
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
        sum       = r_sum;
        cout      = r_cout;
        ovf       = r_ovf;
    end

endmodule
`default_nettype wire

// File: doc/cla_nibble_serial_adder_ctrl.md
Name: cla_nibble_serial_adder_ctrl

Overview:
- Sequencer that performs WIDTH-bit additions by time-multiplexing one four_bit_CLA_adder instance over WIDTH/4 cycles, one nibble per cycle, LSB first.
- Carry is chained through a register.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Lets wide adds share the single 4-bit CLA datapath at low area cost.

Parameters:
- WIDTH, 16, operand/result width in bits; legal values are multiples of 4 and >= 4.
- NIBBLES, WIDTH/4, derived constant, not overridable.
- IDX_W, max(1, clog2(NIBBLES)), derived nibble-counter width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a, b, cin presented
- in_ready  output  1  controller can accept operands (high only in IDLE)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in to nibble 0
- out_valid  output  1  result fields valid (high only in DONE)
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered result
- cout  output  1  carry out of the MSB nibble
- ovf  output  1  two's-complement signed overflow
- busy  output  1  high in RUN or DONE

Behaviour:
- One clock. Reset is synchronous and active-high. Ports are named clk and rst.
- Reset: state=IDLE, idx=0, carry_r=0, a_r=b_r=0. Outputs: sum=0, cout=0, ovf=0, out_valid=0, in_ready=1, busy=0.
- Reset takes priority over every other event, including mid-RUN and mid-DONE. Partial results are discarded and no out_valid is produced.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready: latch a_r<=a, b_r<=b, carry_r<=cin, idx<=0, clear sum to 0, go to RUN.
  - RUN: adder is driven with a=a_r[4*idx+:4], b=b_r[4*idx+:4] (optionally inverted, see feature), c0=carry_r. Each cycle: sum[4*idx+:4]<=adder sum; carry_r<=adder c4; idx<=idx+1. When idx==NIBBLES-1, additionally set cout<=adder c4, compute ovf, and go to DONE.
  - DONE: out_valid=1. sum, cout and ovf hold stable until out_valid&out_ready, then go to IDLE. in_ready re-asserts the following cycle.
- Latency: out_valid rises exactly NIBBLES+1 edges after the accepting edge. Issue interval is at least NIBBLES+2 cycles; there is no overlap of transactions.
- ovf = (a_r[WIDTH-1] == beff[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]), where beff is the effective B operand after optional inversion.
- in_valid outside IDLE is ignored. Operands are not sampled and no error is raised.
- sum, cout and ovf are don't-care to consumers while out_valid=0, but are never X after reset.
- out_ready may be held low indefinitely. DONE persists and outputs stay frozen.
- WIDTH=4: RUN lasts one cycle; idx is always 0.
- Wrap: idx never exceeds NIBBLES-1. The RUN->DONE transition occurs on the last nibble.

Optional Feature:
- Macro: CLA_SEQ_SUB_EN.
- Defined:
  - Adds input port op_sub (1 bit), latched with the operands on acceptance.
  - When op_sub=1: beff=~b_r, and nibble-0 carry-in is 1 (cin is ignored). Result is a-b.
  - cout=1 means no borrow. ovf uses beff.
- Not defined: no op_sub port, beff=b_r, and cin is used as-is.

Decomposition:
- Package cla_seq_pkg holds:
  - state enum {IDLE, RUN, DONE} (2-bit encoding)
  - the NIBBLE_W=4 constant
  - a function computing IDX_W from WIDTH
- Single sub-module: the existing four_bit_CLA_adder, instantiated once (ports sum, c4, a, b, c0). All sequencing stays in this module.

Test Plan:
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. out_valid rises 5 edges after acceptance.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0.
- Hold out_ready=0 for 6 cycles after out_valid -> out_valid stays 1, sum stable, in_ready=0. A new in_valid pulse in this window is ignored; the next transaction uses only the operands presented after in_ready returns.
- Assert rst for 1 cycle while idx=2 in RUN -> next cycle in IDLE, in_ready=1, out_valid=0, sum=0. No result is ever emitted for the aborted operation.
- WIDTH=4 build: a=0x9, b=0x8, cin=0 -> sum=0x1, cout=1, ovf=1, out_valid 2 edges after acceptance.
- CLA_SEQ_SUB_EN build: op_sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0. op_sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1.
